// File: rtl/sobel_cfg_scheduler.sv
// Sobel configuration scheduler: stages register writes and applies them at frame start,
// with an optional per-frame threshold sweep and stream geometry checking.
module sobel_cfg_scheduler #(
  parameter int unsigned IMG_WIDTH         = 640,
  parameter int unsigned IMG_HEIGHT        = 480,
  parameter int unsigned DEFAULT_THRESHOLD = 64
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       cfg_wr,
  input  logic       cfg_enable,
  input  logic [7:0] cfg_threshold,
  input  logic [1:0] cfg_kernel,
  input  logic       cfg_model,
  input  logic [3:0] cfg_debug_cmd,
  input  logic       sweep_en,
  input  logic [7:0] sweep_step,
  input  logic [3:0] sweep_frames,
  input  logic       mon_tvalid,
  input  logic       mon_tready,
  input  logic       mon_tuser,
  input  logic       mon_tlast,
  output logic       sobel_enable,
  output logic [7:0] sobel_threshold,
  output logic [1:0] sobel_kernel,
  output logic       sobel_model,
  output logic [3:0] debug_cmd,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic [15:0] frame_cnt,
  output logic       line_err,
  output logic       frame_err
);

  localparam logic [15:0] Width     = 16'(IMG_WIDTH);
  localparam logic [15:0] Height    = 16'(IMG_HEIGHT);
  localparam logic [7:0]  DefThresh = 8'(DEFAULT_THRESHOLD);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e      state_q, state_d;
  logic        sh_en_q, sh_en_d, sh_model_q, sh_model_d;
  logic [7:0]  sh_thr_q, sh_thr_d;
  logic [1:0]  sh_kern_q, sh_kern_d;
  logic [3:0]  sh_dbg_q, sh_dbg_d;
  logic        en_q, en_d, model_q, model_d;
  logic [7:0]  thr_q, thr_d;
  logic [1:0]  kern_q, kern_d;
  logic [3:0]  dbg_q, dbg_d;
  logic        busy_q, busy_d, done_q, done_d, lerr_q, lerr_d, ferr_q, ferr_d;
  logic        seen_sof_q, seen_sof_d;
  logic [15:0] fcnt_q, fcnt_d, pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic [3:0]  sweep_cnt_q, sweep_cnt_d;

  logic        beat, sof, eol;
  logic [15:0] pix_len;

  assign beat    = mon_tvalid & mon_tready;
  assign sof     = beat & mon_tuser;
  assign eol     = beat & mon_tlast;
  // The SOF beat starts a fresh line as pixel 1.
  assign pix_len = sof ? 16'd1 : pix_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    sh_en_d     = sh_en_q;
    sh_thr_d    = sh_thr_q;
    sh_kern_d   = sh_kern_q;
    sh_model_d  = sh_model_q;
    sh_dbg_d    = sh_dbg_q;
    en_d        = en_q;
    thr_d       = thr_q;
    kern_d      = kern_q;
    model_d     = model_q;
    dbg_d       = dbg_q;
    done_d      = 1'b0;
    sweep_cnt_d = sweep_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (sweep_en && sof) begin
          if (sweep_cnt_q == sweep_frames) begin
            thr_d       = thr_q + sweep_step;
            sweep_cnt_d = '0;
          end else begin
            sweep_cnt_d = sweep_cnt_q + 4'd1;
          end
        end
        if (cfg_wr) state_d = StPending;
      end
      StPending: begin
        // Old shadow is applied even when a new write lands on the same SOF.
        if (sof) begin
          en_d        = sh_en_q;
          thr_d       = sh_thr_q;
          kern_d      = sh_kern_q;
          model_d     = sh_model_q;
          dbg_d       = sh_dbg_q;
          done_d      = 1'b1;
          sweep_cnt_d = '0;
          state_d     = cfg_wr ? StPending : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (cfg_wr) begin
      sh_en_d    = cfg_enable;
      sh_thr_d   = cfg_threshold;
      sh_kern_d  = cfg_kernel;
      sh_model_d = cfg_model;
      sh_dbg_d   = cfg_debug_cmd;
    end
    if (!sweep_en) sweep_cnt_d = '0;
    busy_d = (state_d == StPending);
  end

  always_comb begin
    fcnt_d     = fcnt_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    lerr_d     = lerr_q;
    ferr_d     = ferr_q;
    seen_sof_d = seen_sof_q;
    if (sof) fcnt_d = fcnt_q + 16'd1;
    if (beat) begin
      if (eol) begin
        if (pix_len != Width) lerr_d = 1'b1;
        pix_cnt_d = '0;
      end else begin
        pix_cnt_d = pix_len;
      end
    end
    if (sof) begin
      if (seen_sof_q && (line_cnt_q != Height)) ferr_d = 1'b1;
      seen_sof_d = 1'b1;
      line_cnt_d = eol ? 16'd1 : 16'd0;
    end else if (eol) begin
      line_cnt_d = line_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sh_en_q     <= 1'b0;
      sh_thr_q    <= '0;
      sh_kern_q   <= '0;
      sh_model_q  <= 1'b0;
      sh_dbg_q    <= '0;
      en_q        <= 1'b0;
      thr_q       <= DefThresh;
      kern_q      <= '0;
      model_q     <= 1'b0;
      dbg_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fcnt_q      <= '0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      lerr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      seen_sof_q  <= 1'b0;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sh_en_q     <= sh_en_d;
      sh_thr_q    <= sh_thr_d;
      sh_kern_q   <= sh_kern_d;
      sh_model_q  <= sh_model_d;
      sh_dbg_q    <= sh_dbg_d;
      en_q        <= en_d;
      thr_q       <= thr_d;
      kern_q      <= kern_d;
      model_q     <= model_d;
      dbg_q       <= dbg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fcnt_q      <= fcnt_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      lerr_q      <= lerr_d;
      ferr_q      <= ferr_d;
      seen_sof_q  <= seen_sof_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  assign sobel_enable    = en_q;
  assign sobel_threshold = thr_q;
  assign sobel_kernel    = kern_q;
  assign sobel_model     = model_q;
  assign debug_cmd       = dbg_q;
  assign cfg_busy        = busy_q;
  assign cfg_done        = done_q;
  assign frame_cnt       = fcnt_q;
  assign line_err        = lerr_q;
  assign frame_err       = ferr_q;

endmodule
